// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receiver.
package usb_rx_pkg;

    // Packet status codes reported on rx_packet
    typedef enum logic [2:0] {
        PKT_NONE  = 3'b000,
        PKT_IN    = 3'b001,
        PKT_OUT   = 3'b010,
        PKT_DATA  = 3'b011,
        PKT_ACK   = 3'b100,
        PKT_DONE  = 3'b101,
        PKT_NAK   = 3'b110,
        PKT_ERROR = 3'b111
    } rx_packet_t;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_EOP,
        ST_ERROR
    } rx_state_t;

    // Line states, encoded as {d_plus, d_minus}
    typedef enum logic [1:0] {
        LINE_SE0 = 2'b00,
        LINE_K   = 2'b01,
        LINE_J   = 2'b10,
        LINE_SE1 = 2'b11
    } line_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    // Upper nibble must be the bitwise complement of the lower nibble
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

    // Map a PID byte to its status code; unsupported PIDs are errors
    function automatic rx_packet_t pid_decode(input logic [7:0] pid);
        rx_packet_t code;
        case (pid)
            PID_IN:               code = PKT_IN;
            PID_OUT:              code = PKT_OUT;
            PID_DATA0, PID_DATA1: code = PKT_DATA;
            PID_ACK:              code = PKT_ACK;
            PID_NAK:              code = PKT_NAK;
            default:              code = PKT_ERROR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/usb_rx_if.sv
// Line inputs and endpoint-side outputs of the USB receiver.
interface usb_rx_if;
    import usb_rx_pkg::*;

    logic       d_plus;
    logic       d_minus;
    rx_packet_t rx_packet;
    logic [7:0] rx_packet_data;
    logic       store_rx_packet_data;

    // Bus side: drives the line, observes receiver results
    modport master (
        output d_plus, d_minus,
        input  rx_packet, rx_packet_data, store_rx_packet_data
    );

    // Receiver side
    modport slave (
        input  d_plus, d_minus,
        output rx_packet, rx_packet_data, store_rx_packet_data
    );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// Line synchronizer, bit timing recovery, NRZI decode and bit de-stuffing.
// All per-bit outputs are single-cycle pulses qualified by the mid-bit sample.
module usb_rx_bit_decoder #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    input  logic clear,
    output logic rx_bit,
    output logic bit_valid,
    output logic se0,
    output logic stuff_err,
    output logic j_bit,
    output logic line_j,
    output logic jk_edge
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    dp_sync;
    logic [1:0]    dm_sync;
    logic          dp;
    logic          dm;
    logic          dp_prev;
    logic          dm_prev;
    logic          dp_edge;
    logic          line_k;
    logic          line_se0;
    logic [CW-1:0] timer;
    logic          sample;
    logic          prev_level;
    logic [2:0]    ones;
    logic          stuff_slot;

    assign dp       = dp_sync[1];
    assign dm       = dm_sync[1];
    assign dp_edge  = dp != dp_prev;
    assign line_j   = dp & ~dm;
    assign line_k   = ~dp & dm;
    assign line_se0 = dp == dm;
    assign jk_edge  = dp_edge && line_k && dp_prev && !dm_prev;

    // Two-flop synchronizer plus previous-value flops for edge detection
    always_ff @(posedge clk) begin
        if (n_rst) begin
            dp_sync <= '1;
            dm_sync <= '0;
            dp_prev <= 1'b1;
            dm_prev <= 1'b0;
        end else begin
            dp_sync <= {dp_sync[0], d_plus};
            dm_sync <= {dm_sync[0], d_minus};
            dp_prev <= dp;
            dm_prev <= dm;
        end
    end

    // Bit timer: resynchronised by every D+ transition, samples mid-bit
    always_ff @(posedge clk) begin
        if (n_rst || dp_edge) begin
            timer <= '0;
        end else if (timer == LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + CW'(1);
        end
    end

    assign sample     = !dp_edge && (timer == HALF);
    assign stuff_slot = ones == 3'd6;
    assign rx_bit     = dp == prev_level;
    assign bit_valid  = sample && !line_se0 && !stuff_slot;
    assign stuff_err  = sample && !line_se0 && stuff_slot && rx_bit;
    assign se0        = sample && line_se0;
    assign j_bit      = sample && line_j;

    // NRZI reference level and run-of-ones counter for de-stuffing
    always_ff @(posedge clk) begin
        if (n_rst || clear) begin
            prev_level <= 1'b1;
            ones       <= '0;
        end else if (sample && !line_se0) begin
            prev_level <= dp;
            if (stuff_slot || !rx_bit) begin
                ones <= '0;
            end else begin
                ones <= ones + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_rx.sv
// USB full-speed receiver: SYNC/PID/EOP framing and payload byte delivery.
module usb_rx #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter logic [7:0]  SYNC_BYTE    = usb_rx_pkg::SYNC_BYTE
) (
    input  logic     clk,
    input  logic     n_rst,
    usb_rx_if.slave  bus
);
    import usb_rx_pkg::*;

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    rx_state_t     state_nx;
    logic          rx_bit;
    logic          bit_valid;
    logic          se0;
    logic          stuff_err;
    logic          j_bit;
    logic          line_j;
    logic          jk_edge;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_nx;
    logic          byte_done;
    logic [CW-1:0] j_cnt;
    logic          j_full;
    rx_packet_t    pkt_q;
    rx_packet_t    pkt_nx;
    logic [7:0]    data_q;
    logic [7:0]    data_nx;
    logic          store_q;
    logic          store_nx;

    usb_rx_bit_decoder #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_decoder (
        .clk      (clk),
        .n_rst    (n_rst),
        .d_plus   (bus.d_plus),
        .d_minus  (bus.d_minus),
        .clear    (state == ST_IDLE),
        .rx_bit   (rx_bit),
        .bit_valid(bit_valid),
        .se0      (se0),
        .stuff_err(stuff_err),
        .j_bit    (j_bit),
        .line_j   (line_j),
        .jk_edge  (jk_edge)
    );

    assign byte_nx   = {rx_bit, shift[7:1]};
    assign byte_done = bit_valid && (bit_cnt == 3'd7);
    assign j_full    = line_j && (j_cnt == LAST);

    // LSB-first shift register and bit-in-byte counter
    always_ff @(posedge clk) begin
        if (n_rst || state == ST_IDLE) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (bit_valid) begin
            shift   <= byte_nx;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Measures continuous J while in ERROR
    always_ff @(posedge clk) begin
        if (n_rst || state != ST_ERROR || !line_j) begin
            j_cnt <= '0;
        end else if (!j_full) begin
            j_cnt <= j_cnt + CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (jk_edge) state_nx = ST_SYNC;
            end
            ST_SYNC: begin
                if (se0 || stuff_err) begin
                    state_nx = ST_ERROR;
                end else if (byte_done) begin
                    state_nx = (byte_nx == SYNC_BYTE) ? ST_PID : ST_ERROR;
                end
            end
            ST_PID: begin
                if (se0 || stuff_err) begin
                    state_nx = ST_ERROR;
                end else if (byte_done) begin
                    if (pid_ok(byte_nx) && pid_decode(byte_nx) != PKT_ERROR) begin
                        state_nx = ST_DATA;
                    end else begin
                        state_nx = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                if (stuff_err) begin
                    state_nx = ST_ERROR;
                end else if (se0) begin
                    state_nx = (bit_cnt == 3'd0) ? ST_EOP : ST_ERROR;
                end
            end
            ST_EOP: begin
                if (j_bit) begin
                    state_nx = ST_IDLE;
                end else if (bit_valid || stuff_err) begin
                    state_nx = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (j_full) state_nx = ST_IDLE;
            end
            default: state_nx = ST_ERROR;
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        pkt_nx   = pkt_q;
        data_nx  = data_q;
        store_nx = 1'b0;
        case (state)
            ST_PID: begin
                if (state_nx == ST_DATA) pkt_nx = pid_decode(byte_nx);
            end
            ST_DATA: begin
                if (byte_done) begin
                    data_nx  = byte_nx;
                    store_nx = 1'b1;
                end
            end
            ST_EOP: begin
                if (state_nx == ST_IDLE) pkt_nx = PKT_DONE;
            end
            default: ;
        endcase
        if (state_nx == ST_ERROR) pkt_nx = PKT_ERROR;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (n_rst) begin
            pkt_q   <= PKT_NONE;
            data_q  <= '0;
            store_q <= 1'b0;
        end else begin
            pkt_q   <= pkt_nx;
            data_q  <= data_nx;
            store_q <= store_nx;
        end
    end

    assign bus.rx_packet            = pkt_q;
    assign bus.rx_packet_data       = data_q;
    assign bus.store_rx_packet_data = store_q;

endmodule

// File: tb/tb_usb_rx.sv
// Self-checking bench for usb_rx: NRZI/bit-stuffing line encoder driving
// packets, table of PID vectors, scoreboard of expected payload bytes.
module tb_usb_rx;
    import usb_rx_pkg::*;

    localparam int CPB = 10;

    typedef struct {
        logic [7:0] sync;
        logic [7:0] pid;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         exp_pid;
        int         exp_end;
    } vec_t;

    localparam int NV = 9;

    logic tb_clk = 1'b0;
    logic n_rst;

    usb_rx_if bus();

    usb_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'h80)
    ) dut (
        .clk  (tb_clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    always #5 tb_clk = ~tb_clk;

    int         checks  = 0;
    int         errors  = 0;
    int         n_store = 0;
    logic [7:0] exp_q[$];
    int         per_x10 = 100;
    int         acc     = 0;
    logic       lvl     = 1'b1;
    int         ones    = 0;
    vec_t       vecs[NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every store strobe must match the oldest expected byte
    always @(negedge tb_clk) begin : monitor
        logic [7:0] e;
        if (!n_rst && bus.store_rx_packet_data) begin
            n_store++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: got data %02h expected no store", bus.rx_packet_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.rx_packet_data != e) begin
                    errors++;
                    $display("FAIL store_data: got %02h expected %02h", bus.rx_packet_data, e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_line(input logic dp, input logic dm);
        bus.d_plus  = dp;
        bus.d_minus = dm;
    endtask

    // One bit period, with fractional period accumulated in tenths of a clock
    task automatic hold_bit();
        int n;
        acc = acc + per_x10;
        n   = acc / 10;
        acc = acc - n * 10;
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic send_raw(input logic b);
        if (!b) lvl = ~lvl;
        set_line(lvl, ~lvl);
        hold_bit();
        if (b) ones++;
        else   ones = 0;
    endtask

    task automatic send_bit(input logic b);
        send_raw(b);
        if (ones == 6) send_raw(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic start_packet(input logic [7:0] s);
        lvl  = 1'b1;
        ones = 0;
        send_byte(s);
    endtask

    task automatic send_eop();
        set_line(1'b0, 1'b0);
        hold_bit();
        hold_bit();
        lvl = 1'b1;
        set_line(1'b1, 1'b0);
        repeat (3) hold_bit();
    endtask

    task automatic send_payload(input logic [7:0] b);
        exp_q.push_back(b);
        send_byte(b);
    endtask

    initial begin
        vec_t v;
        int   s0;

        vecs[0] = '{8'h80, 8'hE1, 2, 8'h12, 8'h34, 2, 5};
        vecs[1] = '{8'h80, 8'hC3, 1, 8'hA5, 8'h00, 3, 5};
        vecs[2] = '{8'h80, 8'h4B, 1, 8'h55, 8'h00, 3, 5};
        vecs[3] = '{8'h80, 8'hD2, 0, 8'h00, 8'h00, 4, 5};
        vecs[4] = '{8'h80, 8'h5A, 0, 8'h00, 8'h00, 6, 5};
        vecs[5] = '{8'h80, 8'h68, 0, 8'h00, 8'h00, 7, 7};
        vecs[6] = '{8'h80, 8'h69, 1, 8'h7E, 8'h00, 1, 5};
        vecs[7] = '{8'h80, 8'hA5, 0, 8'h00, 8'h00, 7, 7};
        vecs[8] = '{8'h40, 8'h00, 0, 8'h00, 8'h00, 7, 7};

        set_line(1'b1, 1'b0);
        n_rst = 1'b1;
        repeat (4) @(negedge tb_clk);
        check("rst_pkt", int'(bus.rx_packet), 0);
        check("rst_data", int'(bus.rx_packet_data), 0);
        check("rst_store", int'(bus.store_rx_packet_data), 0);
        n_rst = 1'b0;
        repeat (2) hold_bit();

        // IN token with three payload bytes
        start_packet(8'h80);
        check("after_sync_pkt", int'(bus.rx_packet), 0);
        s0 = n_store;
        send_byte(8'h69);
        check("in_pid", int'(bus.rx_packet), 1);
        check("pid_no_store", n_store - s0, 0);
        send_payload(8'h01);
        send_payload(8'h02);
        send_payload(8'h00);
        send_eop();
        check("in_eop_done", int'(bus.rx_packet), 5);
        check("in_store_count", n_store - s0, 3);
        check("in_last_data", int'(bus.rx_packet_data), 8'h00);

        // PID table
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            start_packet(v.sync);
            if (v.sync == 8'h80) send_byte(v.pid);
            check($sformatf("vec%0d_pid", i), int'(bus.rx_packet), v.exp_pid);
            if (v.nbytes > 0) send_payload(v.b0);
            if (v.nbytes > 1) send_payload(v.b1);
            send_eop();
            check($sformatf("vec%0d_end", i), int'(bus.rx_packet), v.exp_end);
        end

        // DATA0 with payload needing stuffed bits
        start_packet(8'h80);
        send_byte(8'hC3);
        check("data0_pid", int'(bus.rx_packet), 3);
        send_payload(8'hFF);
        send_payload(8'h3F);
        send_eop();
        check("data0_done", int'(bus.rx_packet), 5);

        // Seven consecutive ones mid-DATA
        start_packet(8'h80);
        send_byte(8'hC3);
        s0 = n_store;
        send_raw(1'b0);
        repeat (7) send_raw(1'b1);
        check("stuff_err", int'(bus.rx_packet), 7);
        send_eop();
        check("stuff_err_hold", int'(bus.rx_packet), 7);
        check("stuff_err_no_store", n_store - s0, 0);
        check("stuff_err_data_hold", int'(bus.rx_packet_data), 8'h3F);

        // SE0 after four bits of a byte
        start_packet(8'h80);
        send_byte(8'hC3);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_eop();
        check("se0_mid_byte", int'(bus.rx_packet), 7);

        // Bad PID then reset mid-packet
        start_packet(8'h80);
        send_byte(8'h00);
        check("pid00_err", int'(bus.rx_packet), 7);
        n_rst = 1'b1;
        repeat (2) @(negedge tb_clk);
        check("midrst_pkt", int'(bus.rx_packet), 0);
        check("midrst_data", int'(bus.rx_packet_data), 0);
        check("midrst_store", int'(bus.store_rx_packet_data), 0);
        set_line(1'b1, 1'b0);
        n_rst = 1'b0;
        repeat (2) hold_bit();
        start_packet(8'h80);
        send_byte(8'h69);
        check("post_rst_in", int'(bus.rx_packet), 1);
        send_payload(8'hA0);
        send_eop();
        check("post_rst_done", int'(bus.rx_packet), 5);

        // Bit period drift of -4% and +4%
        for (int k = 0; k < 2; k++) begin
            per_x10 = (k == 0) ? 96 : 104;
            acc     = 0;
            repeat (2) hold_bit();
            start_packet(8'h80);
            send_byte(8'h69);
            check($sformatf("drift%0d_in", per_x10), int'(bus.rx_packet), 1);
            send_payload(8'hC5);
            send_eop();
            check($sformatf("drift%0d_done", per_x10), int'(bus.rx_packet), 5);
        end
        per_x10 = 100;

        repeat (4) hold_bit();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx.md
Name: usb_rx

Overview:
- USB full-speed style serial receiver; the PHY-side front end of the USB endpoint.
- Samples d_plus/d_minus, recovers bit timing, NRZI-decodes and de-stuffs, detects SYNC/PID/EOP.
- Reports the packet type on rx_packet and delivers each received payload byte with a one-cycle store strobe to the endpoint FIFO.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per USB bit period (100 MHz clk, 10 Mb/s line).
- SYNC_BYTE, 8'h80, expected SYNC value, bits assembled LSB-first.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous reset, active-high (port keeps codebase name; 1 = reset, sampled on clk rising edge only).
- d_plus  in  1  USB D+ line, asynchronous.
- d_minus  in  1  USB D- line, asynchronous.
- rx_packet  out  3  packet status code (see Behaviour).
- rx_packet_data  out  8  last received payload byte, LSB = first bit on the wire.
- store_rx_packet_data  out  1  one-cycle strobe: rx_packet_data is valid this cycle.

Behaviour:
- Reset: rx_packet=000, rx_packet_data=8'h00, store_rx_packet_data=0, FSM=IDLE, all counters cleared. Reset mid-packet aborts it.
- Line states: J = (d_plus=1,d_minus=0) idle; K = (0,1); SE0 = (0,0); (1,1) is treated as SE0.
- Inputs pass a 2-flop synchronizer; edge detector on synchronized d_plus.
- Bit timer: restarts on every line transition; samples at count CLKS_PER_BIT/2, then every CLKS_PER_BIT. This gives ±4% drift tolerance.
- NRZI decode: no change from previous sampled level = 1; change = 0. Previous level initialises to J in IDLE.
- Bit de-stuffing: after six consecutive 1s, the next bit is discarded. If that bit is a 1, a stuff error is flagged.
- Bits shift LSB-first into an 8-bit register. A byte is complete on every 8th kept bit.
- FSM states and transitions:
  - IDLE: leaves on the first J-to-K transition, to SYNC.
  - SYNC: after 8 bits, goes to PID if the byte == SYNC_BYTE, else ERROR.
  - PID: after 8 bits, checks PID[7:4] == ~PID[3:0]. Pass: decode, go to DATA. Fail: ERROR.
  - DATA: each completed byte is loaded into rx_packet_data and pulses store_rx_packet_data for exactly 1 cycle. Applies to all packet types, including address/endpoint/CRC bytes; no CRC check in this block. Goes to EOP on SE0 sampled at a byte boundary.
  - EOP: waits for SE0 ≥1 bit then J; sets rx_packet=101, returns to IDLE.
  - ERROR: holds rx_packet=111 until the bus is J for ≥1 bit period, then returns to IDLE.
- rx_packet codes:
  - 000 NONE; 001 IN (PID 0x69); 010 OUT (0xE1); 011 DATA0/DATA1 (0xC3/0x4B); 100 ACK (0xD2); 110 NAK (0x5A).
  - 101 DONE (clean EOP); 111 ERROR. Any other valid PID = ERROR.
- rx_packet updates no later than the end of the last PID bit period, at most 4 cycles after the mid-bit sample. It holds until EOP, error, or reset.
- Error conditions, all give 111:
  - SE0 in the middle of a byte;
  - stuff error;
  - bad SYNC;
  - bad PID complement;
  - SE0 before PID complete.
- rx_packet_data holds its last value between strobes and on errors. No store pulse is generated in SYNC or PID.
- A new SYNC is only accepted from IDLE.

Decomposition:
- Package usb_rx_pkg:
  - rx_packet code enum (NONE, IN, OUT, DATA, ACK, DONE, NAK, ERROR);
  - PID constants;
  - SYNC_BYTE;
  - line-state encodings J/K/SE0.
- Sub-module usb_rx_bit_decoder holds:
  - synchronizer, edge detect, bit timer;
  - NRZI decode, de-stuffing;
  - outputs: bit, bit_valid, se0, stuff_err.
- Top-level usb_rx holds the FSM, shift register, PID decode and output registers.

Test Plan:
- Reset after sending SYNC 0x80 + PID 0x00 → rx_packet=000, rx_packet_data=00, store=0.
- SYNC 0x80 then PID 0x69, 10 clk/bit → rx_packet=000 after SYNC, 001 by end of PID, store never pulses.
- IN token, then bytes 0x01, 0x02, 0x00, then EOP (SE0×2 bits, J) → three store pulses with data 01, 02, 00; rx_packet=101 after EOP.
- PID 0x68 (bad complement) → rx_packet=111, no store; recovers to IDLE and next good IN gives 001.
- DATA0 (0xC3) with payload 0xFF, 0x3F → correct stuffed-bit removal, stores FF then 3F.
- Stuff error from seven 1s mid-DATA → 111. SE0 after 4 bits of a byte → 111.
- Bit period 9.6 clk and 10.4 clk (±4%) → IN packet still decoded as 001.
